// File: rtl/cache_pkg.sv
// Shared types and address helpers for the memory-stage data cache.
// Geometry: 32 lines x 4 halfwords, 8-bit tag, 16-bit byte address.
package cache_pkg;

  localparam int NUM_LINES      = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int TAG_W          = 8;
  localparam int IDX_W          = $clog2(NUM_LINES);
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);
  localparam int ADDR_W         = TAG_W + IDX_W + OFF_W + 1;
  localparam int DATA_W         = 16;
  localparam int CNT_W          = OFF_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    COMPLETE
  } state_t;

  function automatic logic [TAG_W-1:0] addrTag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addrIdx(
    input logic [ADDR_W-1:0] a
  );
    return a[OFF_W+1 +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addrOff(
    input logic [ADDR_W-1:0] a
  );
    return a[1 +: OFF_W];
  endfunction

  function automatic logic [ADDR_W-1:0] wordAddr(
    input logic [TAG_W-1:0] t,
    input logic [IDX_W-1:0] i,
    input logic [OFF_W-1:0] o
  );
    return {t, i, o, 1'b0};
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays of the data cache.
// Reads are combinational; only valid and dirty are cleared by reset.
module dcache_line_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rdIdx,
  input  logic [OFF_W-1:0]  rdOff,
  input  logic [OFF_W-1:0]  wbOff,
  output logic              rdValid,
  output logic              rdDirty,
  output logic [TAG_W-1:0]  rdTag,
  output logic [DATA_W-1:0] rdWord,
  output logic [DATA_W-1:0] wbWord,
  input  logic              wordWe,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [OFF_W-1:0]  wrOff,
  input  logic [DATA_W-1:0] wrData,
  input  logic              metaWe,
  input  logic              metaValid,
  input  logic              metaDirty,
  input  logic [TAG_W-1:0]  metaTag
);

  logic [DATA_W-1:0]    dataArr [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]     tagArr  [NUM_LINES];
  logic [NUM_LINES-1:0] validQ;
  logic [NUM_LINES-1:0] dirtyQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= '0;
      dirtyQ <= '0;
    end else if (metaWe) begin
      validQ[wrIdx] <= metaValid;
      dirtyQ[wrIdx] <= metaDirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wordWe) dataArr[wrIdx][wrOff] <= wrData;
    if (metaWe) tagArr[wrIdx] <= metaTag;
  end

  assign rdValid = validQ[rdIdx];
  assign rdDirty = dirtyQ[rdIdx];
  assign rdTag   = tagArr[rdIdx];
  assign rdWord  = dataArr[rdIdx][rdOff];
  assign wbWord  = dataArr[rdIdx][wbOff];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Hits finish combinationally; misses run writeback then line fill.
module dcache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              stall,
  output logic              cache_hit,
  output logic              err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  state_t state;
  state_t nextState;

  logic [CNT_W-1:0] issCnt;
  logic [CNT_W-1:0] retCnt;

  logic [TAG_W-1:0] reqTag;
  logic [IDX_W-1:0] reqIdx;
  logic [OFF_W-1:0] reqOff;

  logic req;
  logic illegal;
  logic hit;
  logic lastIss;
  logic issDone;
  logic lastRet;

  logic              rdValid;
  logic              rdDirty;
  logic [TAG_W-1:0]  rdTag;
  logic [DATA_W-1:0] rdWord;
  logic [DATA_W-1:0] wbWord;

  logic              wordWe;
  logic [OFF_W-1:0]  wrOff;
  logic [DATA_W-1:0] wrData;
  logic              metaWe;
  logic              metaValid;
  logic              metaDirty;

  assign reqTag = addrTag(req_addr);
  assign reqIdx = addrIdx(req_addr);
  assign reqOff = addrOff(req_addr);

  assign req     = req_rd | req_wr;
  assign illegal = req_addr[0] | (req_rd & req_wr);
  assign hit     = rdValid & (rdTag == reqTag);

  assign lastIss = issCnt == CNT_W'(WORDS_PER_LINE - 1);
  assign issDone = issCnt == CNT_W'(WORDS_PER_LINE);
  assign lastRet = retCnt == CNT_W'(WORDS_PER_LINE - 1);

  dcache_line_store u_store (
    .clk       (clk),
    .rst       (rst),
    .rdIdx     (reqIdx),
    .rdOff     (reqOff),
    .wbOff     (issCnt[OFF_W-1:0]),
    .rdValid   (rdValid),
    .rdDirty   (rdDirty),
    .rdTag     (rdTag),
    .rdWord    (rdWord),
    .wbWord    (wbWord),
    .wordWe    (wordWe),
    .wrIdx     (reqIdx),
    .wrOff     (wrOff),
    .wrData    (wrData),
    .metaWe    (metaWe),
    .metaValid (metaValid),
    .metaDirty (metaDirty),
    .metaTag   (reqTag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (req && !illegal && !hit)
          nextState = (rdValid && rdDirty) ? WB : FILL;
      end
      WB: begin
        if (mem_ready && lastIss) nextState = FILL;
      end
      FILL: begin
        if (mem_rvalid && lastRet) nextState = COMPLETE;
      end
      COMPLETE: nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Issue and return counters run independently so fill reads overlap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issCnt <= '0;
      retCnt <= '0;
    end else begin
      unique case (state)
        WB: begin
          if (mem_ready)
            issCnt <= lastIss ? '0 : issCnt + CNT_W'(1);
        end
        FILL: begin
          if (mem_ready && !issDone) issCnt <= issCnt + CNT_W'(1);
          if (mem_rvalid)            retCnt <= retCnt + CNT_W'(1);
        end
        default: begin
          issCnt <= '0;
          retCnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rdata     = '0;
    done      = 1'b0;
    cache_hit = 1'b0;
    err       = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wordWe    = 1'b0;
    wrOff     = reqOff;
    wrData    = req_wdata;
    metaWe    = 1'b0;
    metaValid = 1'b0;
    metaDirty = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (req && illegal) begin
            err  = 1'b1;
            done = 1'b1;
          end else if (req && hit) begin
            done      = 1'b1;
            cache_hit = 1'b1;
            if (req_rd) begin
              rdata = rdWord;
            end else begin
              wordWe    = 1'b1;
              metaWe    = 1'b1;
              metaValid = 1'b1;
              metaDirty = 1'b1;
            end
          end
        end
        WB: begin
          mem_wr    = 1'b1;
          mem_addr  = wordAddr(rdTag, reqIdx, issCnt[OFF_W-1:0]);
          mem_wdata = wbWord;
        end
        FILL: begin
          mem_rd = !issDone;
          if (!issDone)
            mem_addr = wordAddr(reqTag, reqIdx, issCnt[OFF_W-1:0]);
          if (mem_rvalid) begin
            wordWe = 1'b1;
            wrOff  = retCnt[OFF_W-1:0];
            wrData = mem_rdata;
          end
        end
        COMPLETE: begin
          done      = 1'b1;
          metaWe    = 1'b1;
          metaValid = 1'b1;
          metaDirty = req_wr;
          if (req_wr) wordWe = 1'b1;
          else        rdata  = rdWord;
        end
        default: ;
      endcase
    end
    stall = rst & req & ~done;
  end

endmodule
